avmm_pck_master_bridge: RTL and testbench
=========================================

// Module: avmm_pck_master_bridge
// PURPOSE
// - Converts a native AVMM slave interface (driven by PR user logic) into the packed Tx/Rx
//   vectors consumed by the SR<->PR register stage; sits directly upstream of that stage.
// - Packs commands into one Tx word and unpacks read responses from one Rx word.
// - Limits outstanding read beats and keeps write bursts atomic against interleaved reads.
// PARAMETERS
// - AW          32   address width (bytes)
// - DW          512  data width; DW/8 byteenable bits
// - BCW         7    burstcount width; legal burstcount 1..2**(BCW-1)
// - MAX_RD      64   max outstanding read beats; must be >= 2**(BCW-1)
// - TX_WIDTH    2+AW+DW+DW/8+BCW (derived, do not override)
// - RX_WIDTH    DW+3 (derived, do not override)
// PORTS
// - clk               in   1         single clock
// - i_reset           in   1         asynchronous, active-high reset
// - s_address         in   AW        command address
// - s_read/s_write    in   1 each    command strobes; never both high
// - s_writedata       in   DW        write data
// - s_byteenable      in   DW/8      byte enables
// - s_burstcount      in   BCW       burst length in beats
// - s_waitrequest     out  1         stall to user logic
// - s_readdata        out  DW        read data
// - s_readdatavalid   out  1         read beat valid
// - s_response        out  2         AVMM response code
// - i_m0_waitrequest  in   1         stall from register stage
// - o_m0_pck_Tx       out  TX_WIDTH  {burstcount,byteenable,writedata,address,write,read}, LSB=read
// - i_m0_pck_Rx       in   RX_WIDTH  {response[1:0],readdatavalid,readdata}, LSB=readdata[0]
// - o_err             out  4         sticky: [0] rsp with cnt=0, [1] burstcount=0, [2] rd+wr, [3] wr addr change mid-burst
// BEHAVIOUR
// - Reset (async assert, sync release): s_waitrequest=1, s_readdatavalid=0, s_readdata=0, s_response=0,
//   o_err=0, rd_cnt=0, FSM=IDLE, Tx read/write bits=0.
// - Tx path combinational: address/data/be/bc pass through; read/write bits = s_read/s_write AND NOT blk.
// - s_waitrequest = i_m0_waitrequest | blk | reset-active. Accept = strobe & !s_waitrequest.
// - blk (read) = s_read & (rd_cnt + eff_bc > MAX_RD) or FSM=WR_BURST; blk (write) = 0.
// - eff_bc = (s_burstcount==0) ? 1 : s_burstcount; burstcount 0 sets o_err[1], forwarded as 1.
// - blk only falls while a command is pending (rd_cnt decrements only), so Tx never drops a held command.
// - Rx path: one register stage; s_readdata/s_readdatavalid/s_response = Rx fields +1 clk.
// - rd_cnt: +eff_bc on read accept; -1 on registered readdatavalid; both same cycle -> +eff_bc-1.
//   Width clog2(MAX_RD+1). Beat with rd_cnt==0: set o_err[0], forward beat, rd_cnt stays 0 (no wrap).
// - FSM IDLE: write accept with eff_bc==1 -> IDLE; eff_bc>1 -> WR_BURST, wr_left=eff_bc-1, latch address.
// - FSM WR_BURST: each write accept decrements wr_left; wr_left reaching 0 -> IDLE.
//   Reads blocked; address differing from latched sets o_err[3] (beat still forwarded).
// - s_read & s_write together: o_err[2], both Tx bits forced 0, s_waitrequest=1 that cycle.
// - o_err bits clear only on i_reset.
// - Reset mid-burst or with reads outstanding: all state discarded; caller must reset downstream together.
// STRUCTURE
// - Package avmm_pck_pkg: AW/DW/BCW defaults, Tx/Rx field LSB offsets and widths, response enum
//   (OKAY=0, RSVD=1, SLVERR=2, DECERR=3), FSM enum {IDLE, WR_BURST}, pack/unpack functions.
// - One sub-module avmm_rd_credit: rd_cnt, add/sub, over-limit compare, o_err[0] generation.
// - Top: Tx gating, write-burst FSM, Rx register, error flags.
// TESTING
// - Reset: i_reset pulse mid-simulation -> s_waitrequest=1, o_err=0, Tx read/write=0 next edge.
// - Single read addr 0x100 bc=1, Rx returns beat 3 clk later -> s_readdatavalid 1 clk after Rx, rd_cnt 1->0.
// - MAX_RD=64: two read bursts bc=32 accepted, third bc=1 stalled until one beat returns, then accepted.
// - Write burst bc=4 with s_read asserted between beats 2 and 3 -> read held off until 4th beat accepted.
// - i_m0_waitrequest=1 for 5 clk during write -> Tx word stable all 5 clk, single accept on release.
// - Rx beat with rd_cnt=0 -> o_err[0]=1 sticky, data forwarded; burstcount=0 read -> o_err[1]=1, rd_cnt +1.

Source files
------------

// File: rtl/avmm_pck_pkg.sv
// Shared definitions for the AVMM packed master bridge: default widths,
// packed Tx/Rx field offsets, response codes, FSM states and pack helpers.
package avmm_pck_pkg;

   localparam int AW_DEF     = 32;
   localparam int DW_DEF     = 512;
   localparam int BCW_DEF    = 7;
   localparam int MAX_RD_DEF = 64;

   // Fixed low fields of the Tx word; the rest depend on AW/DW
   localparam int TX_RD_BIT   = 0;
   localparam int TX_WR_BIT   = 1;
   localparam int TX_ADDR_LSB = 2;

   localparam int TX_W_DEF = 2 + AW_DEF + DW_DEF + DW_DEF/8 + BCW_DEF;
   localparam int RX_W_DEF = DW_DEF + 3;

   typedef enum logic [1:0] {
      OKAY   = 2'd0,
      RSVD   = 2'd1,
      SLVERR = 2'd2,
      DECERR = 2'd3
   } avmm_rsp_e;

   typedef enum logic {
      IDLE     = 1'b0,
      WR_BURST = 1'b1
   } wr_state_e;

   function automatic int tx_data_lsb(input int aw);
      return TX_ADDR_LSB + aw;
   endfunction

   function automatic int tx_be_lsb(input int aw, input int dw);
      return TX_ADDR_LSB + aw + dw;
   endfunction

   function automatic int tx_bc_lsb(input int aw, input int dw);
      return TX_ADDR_LSB + aw + dw + dw/8;
   endfunction

   function automatic int rx_valid_bit(input int dw);
      return dw;
   endfunction

   function automatic int rx_rsp_lsb(input int dw);
      return dw + 1;
   endfunction

   // Pack a command at default widths, LSB first: read, write, address, data, be, bc
   function automatic logic [TX_W_DEF-1:0] tx_pack(
      input logic [BCW_DEF-1:0]  bc,
      input logic [DW_DEF/8-1:0] be,
      input logic [DW_DEF-1:0]   wd,
      input logic [AW_DEF-1:0]   addr,
      input logic                wr,
      input logic                rd
   );
      return {bc, be, wd, addr, wr, rd};
   endfunction

   // Unpack the read data field of a default-width Rx word
   function automatic logic [DW_DEF-1:0] rx_data(input logic [RX_W_DEF-1:0] rx);
      return rx[DW_DEF-1:0];
   endfunction

endpackage

// File: rtl/avmm_rd_credit.sv
// Outstanding read beat tracker: adds a burst on read accept, retires one
// beat per returned read beat, and flags beats that arrive with nothing owed.
module avmm_rd_credit
   import avmm_pck_pkg::*;
#(
   parameter int BCW    = BCW_DEF,
   parameter int MAX_RD = MAX_RD_DEF
)(
   input  logic           clk,
   input  logic           i_reset,
   input  logic           add_en,
   input  logic [BCW-1:0] add_bc,
   input  logic           sub_en,
   output logic           over_limit,
   output logic           cnt_err
);

   localparam int CW = $clog2(MAX_RD + 1);
   localparam int SW = ((CW > BCW) ? CW : BCW) + 1;

   logic [CW-1:0] rd_cnt;
   logic [SW-1:0] sum;
   logic [SW-1:0] cnt_next;

   assign sum        = SW'(rd_cnt) + SW'(add_bc);
   assign over_limit = (sum > SW'(MAX_RD));
   assign cnt_err    = sub_en & (rd_cnt == '0);

   // Next count: add the accepted burst, retire a beat unless nothing is owed
   always_comb begin
      cnt_next = SW'(rd_cnt);
      if (add_en) begin
         cnt_next = cnt_next + SW'(add_bc);
      end
      if (sub_en && (rd_cnt != '0)) begin
         cnt_next = cnt_next - SW'(1);
      end
   end

   // Outstanding beat counter register
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         rd_cnt <= '0;
      end else begin
         rd_cnt <= cnt_next[CW-1:0];
      end
   end

endmodule

// File: rtl/avmm_pck_master_bridge.sv
// AVMM slave to packed Tx/Rx bridge: gates commands into the Tx word, keeps
// write bursts atomic, limits outstanding reads and registers read responses.
module avmm_pck_master_bridge
   import avmm_pck_pkg::*;
#(
   parameter int AW       = AW_DEF,
   parameter int DW       = DW_DEF,
   parameter int BCW      = BCW_DEF,
   parameter int MAX_RD   = MAX_RD_DEF,
   localparam int TX_WIDTH = 2 + AW + DW + DW/8 + BCW,
   localparam int RX_WIDTH = DW + 3
)(
   input  logic                clk,
   input  logic                i_reset,
   input  logic [AW-1:0]       s_address,
   input  logic                s_read,
   input  logic                s_write,
   input  logic [DW-1:0]       s_writedata,
   input  logic [DW/8-1:0]     s_byteenable,
   input  logic [BCW-1:0]      s_burstcount,
   output logic                s_waitrequest,
   output logic [DW-1:0]       s_readdata,
   output logic                s_readdatavalid,
   output logic [1:0]          s_response,
   input  logic                i_m0_waitrequest,
   output logic [TX_WIDTH-1:0] o_m0_pck_Tx,
   input  logic [RX_WIDTH-1:0] i_m0_pck_Rx,
   output logic [3:0]          o_err
);

   localparam int RX_VLD = rx_valid_bit(DW);
   localparam int RX_RSP = rx_rsp_lsb(DW);

   wr_state_e      state_q, state_d;
   logic [BCW-1:0] wr_left_q, wr_left_d;
   logic [AW-1:0]  addr_q, addr_d;

   logic           rst_active;
   logic [BCW-1:0] eff_bc;
   logic           both;
   logic           rd_over;
   logic           blk;
   logic           gate;
   logic           tx_rd, tx_wr;
   logic           rd_acc, wr_acc;
   logic           addr_err;
   logic           bc_zero_err;
   logic           cnt_err;

   assign eff_bc = (s_burstcount == '0) ? BCW'(1) : s_burstcount;
   assign both   = s_read & s_write;
   assign blk    = s_read & (rd_over | (state_q == WR_BURST));
   assign gate   = blk | both | rst_active;
   assign tx_rd  = s_read  & ~gate;
   assign tx_wr  = s_write & ~gate;

   assign s_waitrequest = i_m0_waitrequest | gate;
   assign rd_acc        = s_read  & ~s_waitrequest;
   assign wr_acc        = s_write & ~s_waitrequest;
   assign bc_zero_err   = (s_burstcount == '0) & (rd_acc | (wr_acc & (state_q == IDLE)));

   assign o_m0_pck_Tx = {eff_bc, s_byteenable, s_writedata, s_address, tx_wr, tx_rd};

   avmm_rd_credit #(
      .BCW    (BCW),
      .MAX_RD (MAX_RD)
   ) u_credit (
      .clk        (clk),
      .i_reset    (i_reset),
      .add_en     (rd_acc),
      .add_bc     (eff_bc),
      .sub_en     (s_readdatavalid),
      .over_limit (rd_over),
      .cnt_err    (cnt_err)
   );

   // Hold off traffic for the first edge after reset releases
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         rst_active <= 1'b1;
      end else begin
         rst_active <= 1'b0;
      end
   end

   // Write-burst FSM state, remaining beats and latched burst address
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         state_q   <= IDLE;
         wr_left_q <= '0;
         addr_q    <= '0;
      end else begin
         state_q   <= state_d;
         wr_left_q <= wr_left_d;
         addr_q    <= addr_d;
      end
   end

   // Enter a burst on a multi-beat write, count beats down, check address
   always_comb begin
      state_d   = state_q;
      wr_left_d = wr_left_q;
      addr_d    = addr_q;
      addr_err  = 1'b0;
      case (state_q)
         IDLE: begin
            if (wr_acc && (eff_bc > BCW'(1))) begin
               state_d   = WR_BURST;
               wr_left_d = eff_bc - BCW'(1);
               addr_d    = s_address;
            end
         end
         WR_BURST: begin
            if (wr_acc) begin
               addr_err  = (s_address != addr_q);
               wr_left_d = wr_left_q - BCW'(1);
               if (wr_left_q == BCW'(1)) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // One register stage on the read response path
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         s_readdata      <= '0;
         s_readdatavalid <= 1'b0;
         s_response      <= '0;
      end else begin
         s_readdata      <= i_m0_pck_Rx[DW-1:0];
         s_readdatavalid <= i_m0_pck_Rx[RX_VLD];
         s_response      <= i_m0_pck_Rx[RX_RSP +: 2];
      end
   end

   // Sticky protocol error flags, cleared only by reset
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         o_err <= '0;
      end else begin
         o_err <= o_err | {addr_err, both & ~rst_active, bc_zero_err, cnt_err};
      end
   end

endmodule

// File: tb/tb_avmm_pck_master_bridge.sv
// Directed bench for the AVMM packed master bridge: Tx word, stall and error
// flags are checked at each step, read beats go through a scoreboard queue.
module tb_avmm_pck_master_bridge;
   import avmm_pck_pkg::*;

   localparam int AW     = 32;
   localparam int DW     = 32;
   localparam int BCW    = 7;
   localparam int MAX_RD = 64;
   localparam int TXW    = 2 + AW + DW + DW/8 + BCW;
   localparam int RXW    = DW + 3;

   logic            clk = 1'b0;
   logic            i_reset;
   logic [AW-1:0]   s_address;
   logic            s_read;
   logic            s_write;
   logic [DW-1:0]   s_writedata;
   logic [DW/8-1:0] s_byteenable;
   logic [BCW-1:0]  s_burstcount;
   logic            s_waitrequest;
   logic [DW-1:0]   s_readdata;
   logic            s_readdatavalid;
   logic [1:0]      s_response;
   logic            m0_waitrequest;
   logic [TXW-1:0]  m0_pck_tx;
   logic [RXW-1:0]  m0_pck_rx;
   logic [3:0]      err;

   int total = 0;
   int bad   = 0;

   logic [DW+1:0] exp_q[$];

   always #5 clk = ~clk;

   avmm_pck_master_bridge #(
      .AW     (AW),
      .DW     (DW),
      .BCW    (BCW),
      .MAX_RD (MAX_RD)
   ) dut (
      .clk              (clk),
      .i_reset          (i_reset),
      .s_address        (s_address),
      .s_read           (s_read),
      .s_write          (s_write),
      .s_writedata      (s_writedata),
      .s_byteenable     (s_byteenable),
      .s_burstcount     (s_burstcount),
      .s_waitrequest    (s_waitrequest),
      .s_readdata       (s_readdata),
      .s_readdatavalid  (s_readdatavalid),
      .s_response       (s_response),
      .i_m0_waitrequest (m0_waitrequest),
      .o_m0_pck_Tx      (m0_pck_tx),
      .i_m0_pck_Rx      (m0_pck_rx),
      .o_err            (err)
   );

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic rd, input logic wr, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wd, input logic [DW/8-1:0] be,
                                input logic [BCW-1:0] bc);
      s_read       = rd;
      s_write      = wr;
      s_address    = addr;
      s_writedata  = wd;
      s_byteenable = be;
      s_burstcount = bc;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, '0, '0, '0, BCW'(1));
   endtask

   // Present a read beat on Rx and record what the user side must see
   task automatic driveRx(input logic [DW-1:0] data, input logic [1:0] rsp);
      m0_pck_rx = {rsp, 1'b1, data};
      exp_q.push_back({rsp, data});
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   // Expected Tx word: bc (0 forwarded as 1), be, data, address, write, read
   function automatic logic [TXW-1:0] expTx(input logic rd, input logic wr, input logic [AW-1:0] addr,
                                            input logic [DW-1:0] wd, input logic [DW/8-1:0] be,
                                            input logic [BCW-1:0] bc);
      logic [BCW-1:0] bcf;
      bcf = (bc == '0) ? BCW'(1) : bc;
      return {bcf, be, wd, addr, wr, rd};
   endfunction

   // Scoreboard: every registered read beat must match the oldest expectation
   always @(negedge clk) begin
      logic [DW+1:0] e;
      if (!i_reset && s_readdatavalid) begin
         checkOutput("rd_pending", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checkOutput("rd_data", s_readdata, e[DW-1:0]);
            checkOutput("rd_rsp", s_response, e[DW+1:DW]);
         end
      end
   end

   initial begin
      // Reset state, with a read strobe already up
      i_reset        = 1'b1;
      m0_waitrequest = 1'b0;
      m0_pck_rx      = '0;
      applyStimulus(1'b1, 1'b0, 32'h0, '0, 4'hF, BCW'(1));
      mid();
      checkOutput("rst_wait", s_waitrequest, 1'b1);
      checkOutput("rst_txrw", m0_pck_tx[1:0], 2'b00);
      checkOutput("rst_err", err, 4'h0);
      checkOutput("rst_rvalid", s_readdatavalid, 1'b0);
      cyc();
      i_reset = 1'b0;
      idle();
      cyc();
      mid();
      checkOutput("post_rst_wait", s_waitrequest, 1'b0);

      // Single read, beat returned three clocks later
      $display("[TB] single read");
      cyc();
      applyStimulus(1'b1, 1'b0, 32'h100, '0, 4'hF, BCW'(1));
      mid();
      checkOutput("rd1_wait", s_waitrequest, 1'b0);
      checkOutput("rd1_tx", m0_pck_tx, expTx(1'b1, 1'b0, 32'h100, '0, 4'hF, BCW'(1)));
      cyc();
      idle();
      cyc();
      cyc();
      driveRx(32'hDEADBEEF, OKAY);
      cyc();
      m0_pck_rx = '0;
      mid();
      checkOutput("rd1_valid", s_readdatavalid, 1'b1);
      cyc();
      mid();
      checkOutput("rd1_valid_drop", s_readdatavalid, 1'b0);

      // Outstanding limit: 32+32 accepted, a further beat stalls until one returns
      $display("[TB] read credit limit");
      cyc();
      applyStimulus(1'b1, 1'b0, 32'h1000, '0, 4'hF, BCW'(32));
      mid();
      checkOutput("lim_a_wait", s_waitrequest, 1'b0);
      cyc();
      applyStimulus(1'b1, 1'b0, 32'h2000, '0, 4'hF, BCW'(32));
      mid();
      checkOutput("lim_b_wait", s_waitrequest, 1'b0);
      cyc();
      applyStimulus(1'b1, 1'b0, 32'h3000, '0, 4'hF, BCW'(1));
      mid();
      checkOutput("lim_c_wait", s_waitrequest, 1'b1);
      checkOutput("lim_c_txrd", m0_pck_tx[0], 1'b0);
      cyc();
      mid();
      checkOutput("lim_c_hold", s_waitrequest, 1'b1);
      cyc();
      driveRx(32'h000000A0, OKAY);
      mid();
      checkOutput("lim_rx_wait", s_waitrequest, 1'b1);
      cyc();
      m0_pck_rx = '0;
      mid();
      checkOutput("lim_reg_wait", s_waitrequest, 1'b1);
      cyc();
      mid();
      checkOutput("lim_free_wait", s_waitrequest, 1'b0);
      checkOutput("lim_free_txrd", m0_pck_tx[0], 1'b1);
      cyc();
      idle();
      for (int i = 0; i < 64; i++) begin
         driveRx(DW'(32'h100 + i), 2'(i));
         cyc();
      end
      m0_pck_rx = '0;
      cyc();
      applyStimulus(1'b1, 1'b0, 32'h4000, '0, 4'hF, BCW'(64));
      mid();
      checkOutput("lim_drained_wait", s_waitrequest, 1'b0);
      cyc();
      idle();
      for (int i = 0; i < 64; i++) begin
         driveRx(DW'(32'h5000 + i * 3), OKAY);
         cyc();
      end
      m0_pck_rx = '0;
      cyc();

      // Write burst of 4 with a read attempted between beats 2 and 3
      $display("[TB] atomic write burst");
      applyStimulus(1'b0, 1'b1, 32'h200, 32'h11, 4'hF, BCW'(4));
      mid();
      checkOutput("wb1_wait", s_waitrequest, 1'b0);
      checkOutput("wb1_tx", m0_pck_tx, expTx(1'b0, 1'b1, 32'h200, 32'h11, 4'hF, BCW'(4)));
      cyc();
      applyStimulus(1'b0, 1'b1, 32'h200, 32'h22, 4'hF, BCW'(4));
      mid();
      checkOutput("wb2_wait", s_waitrequest, 1'b0);
      cyc();
      applyStimulus(1'b1, 1'b0, 32'h300, '0, 4'hF, BCW'(1));
      mid();
      checkOutput("wb_rd_wait", s_waitrequest, 1'b1);
      checkOutput("wb_rd_tx", m0_pck_tx[1:0], 2'b00);
      cyc();
      applyStimulus(1'b0, 1'b1, 32'h200, 32'h33, 4'hF, BCW'(4));
      mid();
      checkOutput("wb3_wait", s_waitrequest, 1'b0);
      cyc();
      applyStimulus(1'b1, 1'b0, 32'h300, '0, 4'hF, BCW'(1));
      mid();
      checkOutput("wb_rd2_wait", s_waitrequest, 1'b1);
      cyc();
      applyStimulus(1'b0, 1'b1, 32'h200, 32'h44, 4'hF, BCW'(4));
      mid();
      checkOutput("wb4_wait", s_waitrequest, 1'b0);
      checkOutput("wb4_tx", m0_pck_tx, expTx(1'b0, 1'b1, 32'h200, 32'h44, 4'hF, BCW'(4)));
      cyc();
      applyStimulus(1'b1, 1'b0, 32'h300, '0, 4'hF, BCW'(1));
      mid();
      checkOutput("wb_rd3_wait", s_waitrequest, 1'b0);
      checkOutput("wb_rd3_txrd", m0_pck_tx[0], 1'b1);
      cyc();
      idle();
      driveRx(32'h00005555, SLVERR);
      cyc();
      m0_pck_rx = '0;
      cyc();
      mid();
      checkOutput("err_clean", err, 4'h0);

      // Downstream stall during a single write: Tx word held, one accept
      $display("[TB] downstream stall");
      cyc();
      m0_waitrequest = 1'b1;
      applyStimulus(1'b0, 1'b1, 32'h400, 32'hCAFE, 4'h3, BCW'(1));
      for (int k = 0; k < 5; k++) begin
         mid();
         checkOutput("stall_tx", m0_pck_tx, expTx(1'b0, 1'b1, 32'h400, 32'hCAFE, 4'h3, BCW'(1)));
         checkOutput("stall_wait", s_waitrequest, 1'b1);
         cyc();
      end
      m0_waitrequest = 1'b0;
      mid();
      checkOutput("stall_rel_wait", s_waitrequest, 1'b0);
      checkOutput("stall_rel_tx", m0_pck_tx, expTx(1'b0, 1'b1, 32'h400, 32'hCAFE, 4'h3, BCW'(1)));
      cyc();
      applyStimulus(1'b1, 1'b0, 32'h500, '0, 4'hF, BCW'(1));
      mid();
      checkOutput("stall_after_rd", s_waitrequest, 1'b0);
      cyc();
      idle();
      driveRx(32'h00A5A5A5, OKAY);
      cyc();
      m0_pck_rx = '0;
      cyc();

      // Beat with nothing outstanding: forwarded, err[0] sticky
      $display("[TB] error flags");
      driveRx(32'h0000BAD0, DECERR);
      cyc();
      m0_pck_rx = '0;
      cyc();
      mid();
      checkOutput("err0", err, 4'b0001);

      // Burstcount 0 read: forwarded as 1, err[1], one beat owed
      cyc();
      applyStimulus(1'b1, 1'b0, 32'h600, '0, 4'hF, BCW'(0));
      mid();
      checkOutput("bc0_wait", s_waitrequest, 1'b0);
      checkOutput("bc0_tx", m0_pck_tx, expTx(1'b1, 1'b0, 32'h600, '0, 4'hF, BCW'(0)));
      cyc();
      applyStimulus(1'b1, 1'b0, 32'h700, '0, 4'hF, BCW'(64));
      mid();
      checkOutput("err1", err, 4'b0011);
      checkOutput("bc0_owed_wait", s_waitrequest, 1'b1);
      cyc();
      idle();
      driveRx(32'h00006060, OKAY);
      cyc();
      m0_pck_rx = '0;
      cyc();
      applyStimulus(1'b1, 1'b0, 32'h700, '0, 4'hF, BCW'(64));
      mid();
      checkOutput("bc0_clear_wait", s_waitrequest, 1'b0);
      cyc();

      // Read and write together: both Tx bits off, stall, err[2]
      applyStimulus(1'b1, 1'b1, 32'h800, 32'h1, 4'hF, BCW'(1));
      mid();
      checkOutput("both_wait", s_waitrequest, 1'b1);
      checkOutput("both_tx", m0_pck_tx[1:0], 2'b00);
      cyc();
      idle();
      mid();
      checkOutput("err2", err, 4'b0111);

      // Address change mid write burst: beat forwarded, err[3]
      cyc();
      applyStimulus(1'b0, 1'b1, 32'h900, 32'h1, 4'hF, BCW'(2));
      mid();
      checkOutput("adr1_wait", s_waitrequest, 1'b0);
      cyc();
      applyStimulus(1'b0, 1'b1, 32'h904, 32'h2, 4'hF, BCW'(2));
      mid();
      checkOutput("adr2_wait", s_waitrequest, 1'b0);
      checkOutput("adr2_tx", m0_pck_tx, expTx(1'b0, 1'b1, 32'h904, 32'h2, 4'hF, BCW'(2)));
      cyc();
      idle();
      mid();
      checkOutput("err3", err, 4'b1111);

      // Reset mid-run with 64 beats outstanding: everything discarded
      $display("[TB] reset mid run");
      cyc();
      applyStimulus(1'b1, 1'b0, 32'hA00, '0, 4'hF, BCW'(1));
      i_reset = 1'b1;
      mid();
      checkOutput("mrst_wait", s_waitrequest, 1'b1);
      checkOutput("mrst_err", err, 4'h0);
      checkOutput("mrst_txrw", m0_pck_tx[1:0], 2'b00);
      cyc();
      i_reset = 1'b0;
      idle();
      cyc();
      applyStimulus(1'b1, 1'b0, 32'hB00, '0, 4'hF, BCW'(64));
      mid();
      checkOutput("mrst_rd_wait", s_waitrequest, 1'b0);
      checkOutput("mrst_err_after", err, 4'h0);
      cyc();
      idle();
      cyc();

      checkOutput("sb_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
